// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg
//   Shared definitions for the register-file debug dump engine.
//   - Default geometry (NUM_REGS / ADDR_W / DATA_W), also used by the
//     register file itself.
//   - FSM state encodings and the dump_state_t enum built on them.
//   Optional feature macro: REGFILE_DUMP_CSUM_EN adds the CSUM state.
package regfile_dump_pkg;

    localparam int REGFILE_NUM_REGS = 32;
    localparam int REGFILE_ADDR_W   = 5;
    localparam int REGFILE_DATA_W   = 32;

    // Legacy state encodings, kept stable for existing trace decoders.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
`ifdef REGFILE_DUMP_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

`ifdef REGFILE_DUMP_CSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_SEND = S_SEND,
        ST_CSUM = S_CSUM,
        ST_DONE = S_DONE
    } dump_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_SEND = S_SEND,
        ST_DONE = S_DONE
    } dump_state_t;
`endif

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug read-out engine: on start, walks every register through a
//   dedicated register-file read port and streams each value out on a
//   valid/ready interface. Read-only; never stalls the core.
//
//   Optional feature macro: REGFILE_DUMP_CSUM_EN
//     defined   : one extra word (XOR of all dumped values) follows the last
//                 register; out_last marks only that word.
//     undefined : no checksum word; out_last marks the last register word.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        dump request, honoured only in IDLE
//   busy         high while a dump is in progress (through DONE)
//   done         one-cycle pulse at dump completion
//   RdAddr       register index to the register-file read port
//   RdData       combinational read data for RdAddr
//   out_valid    stream word valid
//   out_ready    consumer ready
//   out_data     register value or checksum
//   out_idx      register index of out_data (0 for checksum)
//   out_last     final word of the dump
//   out_is_csum  word is the checksum
import regfile_dump_pkg::*;

module regfile_dump #(
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int DATA_W   = REGFILE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              out_is_csum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_q;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif
    logic              accept;

    assign accept = out_valid && out_ready;
    assign RdAddr = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            data_q <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= '0;
`ifdef REGFILE_DUMP_CSUM_EN
                        csum_q <= '0;
`endif
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    data_q <= RdData;
`ifdef REGFILE_DUMP_CSUM_EN
                    csum_q <= csum_q ^ RdData;
`endif
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
`ifdef REGFILE_DUMP_CSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
`ifdef REGFILE_DUMP_CSUM_EN
                ST_CSUM: begin
                    if (accept) state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    // idx returns to 0 so RdAddr reads 0 again in IDLE
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        out_valid   = 1'b0;
        out_data    = '0;
        out_idx     = '0;
        out_last    = 1'b0;
        out_is_csum = 1'b0;
        case (state)
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = data_q;
                out_idx   = idx;
`ifndef REGFILE_DUMP_CSUM_EN
                out_last  = (idx == LAST_IDX);
`endif
            end
`ifdef REGFILE_DUMP_CSUM_EN
            ST_CSUM: begin
                out_valid   = 1'b1;
                out_data    = csum_q;
                out_is_csum = 1'b1;
                out_last    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the single-cycle core's register file. On a start pulse it walks every architectural register through a dedicated register-file read port and emits each 32-bit value as a valid/ready stream toward the debug/trace path. It is the reader counterpart to the writeback path: it only reads, never writes, and it does not stall the core.

## Interface
Parameters:
- NUM_REGS, 32, number of registers walked, indices 0..NUM_REGS-1
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS
- DATA_W, 32, register data width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  request a dump; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse when the dump completes
- RdAddr  out  ADDR_W  register index driven to the register file's read port
- RdData  in  DATA_W  combinational read data returned for RdAddr
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_W  register value, or checksum word
- out_idx  out  ADDR_W  register index of out_data
- out_last  out  1  marks the final word of the dump
- out_is_csum  out  1  marks the checksum word

## Operation
- States: IDLE, LOAD, SEND, CSUM (macro only), DONE.
- IDLE: when start=1, set idx=0 and go to LOAD. Otherwise stay.
- LOAD: RdAddr=idx. Capture RdData into data_q. XOR it into csum_q when the macro is on. Go to SEND.
- SEND: out_valid=1, out_data=data_q, out_idx=idx. The word is accepted on a cycle with out_valid&&out_ready.
  - On accept with idx==NUM_REGS-1: go to CSUM if the macro is on, else to DONE.
  - On any other accept: idx++ and go to LOAD.
  - With no accept: hold all outputs stable.
- CSUM: out_valid=1, out_data=csum_q, out_idx=0, out_is_csum=1, out_last=1. On accept go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- RdAddr equals idx in every state; it is 0 in IDLE.
- Register 0 is read like any other index; no special-casing.
- There is no snapshot. Each word reflects the register value in its own LOAD cycle. A register written by the core during a dump shows the new value only if it is written before that index's LOAD.
- start while busy is ignored; a held start does not retrigger until DONE has returned to IDLE.
- csum_q is cleared on an accepted start.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_is_csum=0, out_data=0, out_idx=0, RdAddr=0. State is IDLE; idx and csum_q are 0.
- Start accepted at cycle T: LOAD at T+1; first out_valid at T+2.
- Throughput: at best one word every 2 cycles (LOAD then SEND).
- Full dump with out_ready held at 1: done pulses at T+2·NUM_REGS+1 without the macro, and at T+2·NUM_REGS+2 with it.
- The index counter stops at NUM_REGS-1 and never wraps.
- rst mid-dump: all state returns to reset values on the next edge, even with out_valid high. No done pulse is produced.
- Once out_valid is asserted it is not deasserted before an accept; this is the standard valid/ready rule.

## Configuration
- REGFILE_DUMP_CSUM_EN defined:
  - After the last register, one extra word carries the XOR of all dumped values.
  - out_last is asserted only on that checksum word.
- Not defined:
  - No CSUM state and no csum_q.
  - out_is_csum is tied to 0.
  - out_last is asserted on the idx==NUM_REGS-1 word.

## Structure
- Shared package regfile_dump_pkg holds:
  - the state enum typedef dump_state_t;
  - the default constants for NUM_REGS, ADDR_W and DATA_W, reused by the register file.
- The design is a single module with no sub-module. The FSM, idx counter, data_q and csum_q are small enough to keep inline.

## Test plan
- Reset, then idle: all outputs are at their reset values and RdAddr=0.
- Model regs[i]=0x100+i, out_ready=1, one start pulse:
  - 32 words arrive with out_idx 0..31 and data 0x100..0x11F.
  - done pulses at T+65 without the macro, or T+66 with it.
- With the macro, all regs 0 except regs[2]=0x000003FC and regs[5]=0xDEADBEEF:
  - the checksum word is 0xDEADBD13 with out_is_csum=1 and out_last=1;
  - the preceding index-31 word has out_last=0.
- Random out_ready backpressure at 30% duty: out_data and out_idx stay stable while valid&&!ready. There is no word loss or duplication.
- start re-pulsed at words 3 and 17: no restart; exactly 32 (or 33) words total.
- rst asserted while SEND is at idx=10: next cycle out_valid=0, busy=0, no done. A fresh start then dumps from idx 0.
